alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Sequential front end and result-capture stage for the 4-function ALU (add, subtract, OR, AND) with a 5-bit flag output. The block accepts operands and an opcode one word at a time over a valid/ready input port, and runs the combinational ALU core. It then registers Result and Flags and presents them on a valid/ready output port. Chaining lets the captured result serve as operand A of the next operation, so multi-step arithmetic can run from switches/buttons or from a host.

## Interface
- M, 4: operand/result width; M ≥ 3 (the opcode word uses bits [2:0]).
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_data  input  M  operand word (A or B), or opcode word: [1:0]=OpCode, [2]=chain, other bits ignored.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- result  output  M  registered ALU result.
- flags  output  5  registered {N, Z, C, V, P}.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result this cycle.
- op_count  output  8  number of completed (accepted) operations, wraps 255→0.

## Operation
- OpCode encoding: 00 = A−B, 01 = A+B, 10 = A|B, 11 = A&B.
- Flag definitions:
  - N = result[M-1].
  - Z = (result == 0).
  - P = ^result (1 when an odd number of bits are set).
  - Add: C = carry out of bit M-1; V = signed overflow.
  - Sub: C = borrow (A < B unsigned); V = signed overflow.
  - OR/AND: C = V = 0.
- All arithmetic is M+1 bits wide internally; result is truncated to M bits.
- States:
  - LOAD_A → LOAD_B → LOAD_OP → EXEC → HOLD.
  - From HOLD, on an out handshake: go to LOAD_B if the stored chain bit is 1, else LOAD_A.
- LOAD_A/LOAD_B/LOAD_OP: in_ready=1; on in_valid&&in_ready, latch into A, B or {chain, op}, then advance.
- EXEC: in_ready=0; capture ALU outputs into result/flags; go to HOLD.
- HOLD: out_valid=1. result and flags stay stable until out_valid&&out_ready. On that handshake: op_count increments; if chain=1, A ← result.
- in_valid while in_ready=0 is ignored; the data is not stored.
- A and B are stored unmodified; the opcode word's upper bits are discarded.

## Timing
- Reset values: in_ready=0 during reset and 1 on the first cycle after (state LOAD_A); out_valid=0, result=0, flags=0, op_count=0, A=B=0, chain=0.
- Reset mid-operation, in any state: return to LOAD_A next cycle; a pending result is lost; op_count clears.
- Latency: opcode handshake at edge k → EXEC in cycle k+1 → out_valid=1 from cycle k+2.
- Minimum sequence period: 5 cycles unchained (3 loads, EXEC, 1 HOLD cycle with out_ready=1); 4 cycles chained.
- out_ready held high: HOLD lasts exactly one cycle. out_valid deasserts the cycle after the handshake.
- out_ready low: HOLD persists indefinitely; in_ready stays 0 (no overlap of input and output phases).
- op_count updates on the same edge as the out handshake.
- No combinational path from any input to any output; in_ready and out_valid decode from the state register.

## Structure
- Package alu_pkg holds:
  - opcode enum (OP_SUB, OP_ADD, OP_OR, OP_AND);
  - state enum;
  - flag index constants (FLAG_N=4, FLAG_Z=3, FLAG_C=2, FLAG_V=1, FLAG_P=0).
- One sub-module, alu_core #(M): purely combinational; (A, B, OpCode) → (Result, Flags). It is instantiated once inside the sequencer.
- The sequencer holds the FSM, the operand/op registers, the output registers and op_count.

## Test plan
All scenarios use M=4.
- Add: load A=0001, B=1111, op=01 → result=0000, flags=01100; out_valid first seen 2 cycles after the op handshake.
- Sub: A=0000, B=0001, op=00 → 1111, flags=10100. Sub: A=1000, B=0110 → 0010, flags=00011.
- Overflow and logic ops:
  - add 0100+0100 → 1000, flags=10011;
  - OR 0010|1100 → 1110, flags=10001;
  - AND 1111&1111 → 1111, flags=10000.
- Chain: A=0001, B=0001, op word=101 (add, chain) → 0010; next accepts only B=0011 and op=001 → 0101, flags=00000; op_count=2.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD → result/flags stable, in_ready=0, in_valid pulses ignored, op_count unchanged; then out_ready=1 → exactly one increment.
- Reset: assert reset_n=0 in LOAD_OP and again in HOLD → next cycle state LOAD_A, out_valid=0, result=0, op_count=0; the following full sequence works normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequenced 4-function ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_ADD = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_OP,
        S_EXEC,
        S_HOLD
    } state_e;

    localparam int FLAGS_W = 5;
    localparam int FLAG_N  = 4;
    localparam int FLAG_Z  = 3;
    localparam int FLAG_C  = 2;
    localparam int FLAG_V  = 1;
    localparam int FLAG_P  = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: sub/add/or/and on M-bit operands with {N,Z,C,V,P} flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0]       a,
    input  logic [M-1:0]       b,
    input  opcode_e            opcode,
    output logic [M-1:0]       result,
    output logic [FLAGS_W-1:0] flags
);

    logic        [M:0] sum_u;
    logic        [M:0] diff_u;
    logic signed [M:0] a_s;
    logic signed [M:0] b_s;
    logic signed [M:0] sum_s;
    logic signed [M:0] diff_s;
    logic              carry;
    logic              ovf;

    // Unsigned M+1 results give carry/borrow; sign-extended ones expose overflow
    // as a mismatch between their top two bits.
    assign sum_u  = {1'b0, a} + {1'b0, b};
    assign diff_u = {1'b0, a} - {1'b0, b};
    assign a_s    = signed'({a[M-1], a});
    assign b_s    = signed'({b[M-1], b});
    assign sum_s  = a_s + b_s;
    assign diff_s = a_s - b_s;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        unique case (opcode)
            OP_SUB: begin
                result = diff_u[M-1:0];
                carry  = diff_u[M];
                ovf    = diff_s[M] ^ diff_s[M-1];
            end
            OP_ADD: begin
                result = sum_u[M-1:0];
                carry  = sum_u[M];
                ovf    = sum_s[M] ^ sum_s[M-1];
            end
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            default: result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[M-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
        flags[FLAG_P] = ^result;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads A, B and an opcode word over valid/ready, runs the ALU once and holds
// the registered result until the consumer takes it; optional result chaining.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int M = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [M-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [M-1:0]       result,
    output logic [FLAGS_W-1:0] flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         op_count
);

    state_e               state;
    state_e               state_nx;
    logic                 rst_hold;
    logic [M-1:0]         a_q;
    logic [M-1:0]         b_q;
    opcode_e              op_q;
    logic                 chain_q;
    logic [M-1:0]         alu_result;
    logic [FLAGS_W-1:0]   alu_flags;
    logic                 in_hs;
    logic                 out_hs;

    alu_core #(.M(M)) u_core (
        .a      (a_q),
        .b      (b_q),
        .opcode (op_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // rst_hold keeps in_ready low for as long as reset is held, while the
    // state register already sits in LOAD_A.
    assign in_ready  = !rst_hold &&
                       (state == S_LOAD_A || state == S_LOAD_B || state == S_LOAD_OP);
    assign out_valid = (state == S_HOLD);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_LOAD_A:  if (in_hs) state_nx = S_LOAD_B;
            S_LOAD_B:  if (in_hs) state_nx = S_LOAD_OP;
            S_LOAD_OP: if (in_hs) state_nx = S_EXEC;
            S_EXEC:    state_nx = S_HOLD;
            S_HOLD:    if (out_hs) state_nx = chain_q ? S_LOAD_B : S_LOAD_A;
            default:   state_nx = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_LOAD_A;
            rst_hold <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_SUB;
            chain_q  <= 1'b0;
            result   <= '0;
            flags    <= '0;
            op_count <= '0;
        end else begin
            state    <= state_nx;
            rst_hold <= 1'b0;
            if (in_hs && state == S_LOAD_A) a_q <= in_data;
            if (in_hs && state == S_LOAD_B) b_q <= in_data;
            if (in_hs && state == S_LOAD_OP) begin
                op_q    <= opcode_e'(in_data[1:0]);
                chain_q <= in_data[2];
            end
            if (state == S_EXEC) begin
                result <= alu_result;
                flags  <= alu_flags;
            end
            if (out_hs) begin
                op_count <= op_count + 8'd1;
                if (chain_q) a_q <= result;
            end
        end
    end

endmodule
